ef_i2s_apb: RTL and testbench
=============================

EF_I2S_APB -- requirements
Module: ef_i2s_apb

Interface
REQ-001 SHALL have ports: PCLK  in  1  sole clock; all logic on rising edge.
REQ-002 SHALL have port PRESETn  in  1  asynchronous reset, active-high (asserted = 1 despite the suffix).
REQ-003 SHALL have APB ports: PADDR in 32, PWRITE in 1, PSEL in 1, PENABLE in 1, PWDATA in 32, PRDATA out 32, PREADY out 1.
REQ-004 SHALL have I2S ports: sck out 1 bit clock; ws out 1 word select (0 = left, 1 = right); sdi in 1 serial data.
REQ-005 SHALL have IRQ  out  1  level interrupt.
REQ-006 SHALL have parameter FIFO_AW, default 4, giving RX FIFO depth 2^FIFO_AW = 16 words of 32 bits.

Function
REQ-007 SHALL tie PREADY to 1; write occurs on PSEL & PENABLE & PWRITE; PRDATA is combinational from PADDR[15:0], 0 for unmapped addresses.
REQ-008 SHALL map registers: 0x0000 RXDATA RO; 0x0004 PR RW[15:0]; 0x0008 CTRL RW (bit0 EN); 0x000C CFG RW; 0x0010 FIFO_LEVEL RO[4:0]; 0x0014 FIFO_THRESHOLD RW[3:0]; 0x0018 FIFO_FLUSH WO bit0; 0xFF00 IM RW[2:0]; 0xFF04 MIS RO; 0xFF08 RIS RO; 0xFF0C IC W1C[2:0].
REQ-009 SHALL use CFG fields: [1:0] channel (01 left, 10 right, 11 stereo, 00 none); [2] sign-extend; [3] left-justify; [9:4] sample size 1..32 (0 treated as 32).
REQ-010 SHALL, when EN = 1, toggle sck every PR+1 PCLK cycles; with EN = 0 sck and ws are held 0 and bit counter cleared.
REQ-011 SHALL frame 64 sck periods: 32 with ws = 0 then 32 with ws = 1; ws changes on sck falling edge.
REQ-012 SHALL sample sdi on sck rising edge, MSB first, starting on the second rising edge of each slot (one-bit I2S delay), capturing sample-size bits; later bits ignored.
REQ-013 SHALL, at end of a slot whose channel is selected, push the word: right-aligned with zero fill, or sign-extended from bit size-1 when CFG[2] = 1; CFG[3] = 1 left-aligns the word instead (low bits zero), overriding sign extension.
REQ-014 SHALL, in stereo, push left then right as two separate words.
REQ-015 SHALL drop the push when FIFO full (level = 16); FIFO contents unchanged.
REQ-016 SHALL pop one word on an APB read of RXDATA (PSEL & PENABLE & !PWRITE); read when empty returns 0 and does not pop.
REQ-017 SHALL, on simultaneous push and pop, keep level unchanged and both complete (unless empty: push only).
REQ-018 SHALL clear FIFO (level 0, pointers 0) on write of 1 to FIFO_FLUSH bit0; flush takes priority over a same-cycle push.
REQ-019 SHALL set RIS bits sticky each cycle the condition holds: bit0 FIFO level > threshold; bit1 FIFO empty; bit2 FIFO full.
REQ-020 SHALL clear RIS bits written 1 to IC; a set condition in the same cycle wins.
REQ-021 SHALL drive MIS = RIS & IM and IRQ = |MIS, registered one cycle.
REQ-022 SHALL ignore writes to RO registers; PR/CFG changes take effect at next sck edge without resetting the frame.

Reset
REQ-023 SHALL on reset: sck 0, ws 0, IRQ 0, PR 0, CTRL 0, CFG 0x203 (size 32, stereo), threshold 0, IM 0, RIS 0, FIFO empty, bit and slot counters 0.
REQ-024 SHALL abort any in-progress shift on reset mid-frame; partial sample discarded.

Verification
REQ-025 Reset then read all registers -> values of REQ-023; FIFO_LEVEL 0, RIS after one cycle = 0x2 (empty).
REQ-026 PR=1, EN=1, CFG size 16 stereo, drive sdi left 0xA5A5, right 0x1234 -> reads 0x0000A5A5 then 0x00001234; sck period 4 PCLK.
REQ-027 CFG size 16 sign-extend, left 0x8001 -> RXDATA 0xFFFF8001; left-justify -> 0x80010000.
REQ-028 Threshold 3, IM=1, receive 4 words -> RIS bit0 set, IRQ 1; write IC=1 after draining -> IRQ 0.
REQ-029 Receive 20 words without reading -> FIFO_LEVEL 16, RIS bit2 set, first 16 words returned in order.
REQ-030 Read RXDATA on empty FIFO -> 0, level stays 0; FIFO_FLUSH with 5 words -> level 0.

Source files
------------

// File: rtl/ef_i2s_apb.sv
// I2S receiver that masters sck/ws and feeds a 32-bit RX FIFO. Registers, FIFO
// and interrupt status are exposed on a zero-wait-state APB slave.
`timescale 1ns/1ps
module ef_i2s_apb #(
  parameter int FIFO_AW = 4
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        sck,
  output logic        ws,
  input  logic        sdi,
  output logic        IRQ
);
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [15:0] A_RXDATA = 16'h0000;
  localparam logic [15:0] A_PR     = 16'h0004;
  localparam logic [15:0] A_CTRL   = 16'h0008;
  localparam logic [15:0] A_CFG    = 16'h000C;
  localparam logic [15:0] A_LEVEL  = 16'h0010;
  localparam logic [15:0] A_THR    = 16'h0014;
  localparam logic [15:0] A_FLUSH  = 16'h0018;
  localparam logic [15:0] A_IM     = 16'hFF00;
  localparam logic [15:0] A_MIS    = 16'hFF04;
  localparam logic [15:0] A_RIS    = 16'hFF08;
  localparam logic [15:0] A_IC     = 16'hFF0C;

  logic [15:0] addr;
  logic        wr_en;
  logic        rd_en;

  assign addr   = PADDR[15:0];
  assign wr_en  = PSEL & PENABLE & PWRITE;
  assign rd_en  = PSEL & PENABLE & ~PWRITE;
  assign PREADY = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{PADDR[31:16], PWDATA[31:16]};

  logic [15:0] pr;
  logic        en;
  logic [9:0]  cfg;
  logic [3:0]  thr;
  logic [2:0]  im;
  logic [2:0]  ris;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      pr  <= '0;
      en  <= 1'b0;
      cfg <= 10'h203;
      thr <= '0;
      im  <= '0;
    end else if (wr_en) begin
      case (addr)
        A_PR:    pr  <= PWDATA[15:0];
        A_CTRL:  en  <= PWDATA[0];
        A_CFG:   cfg <= PWDATA[9:0];
        A_THR:   thr <= PWDATA[3:0];
        A_IM:    im  <= PWDATA[2:0];
        default: ;
      endcase
    end
  end

  // Bit clock, frame position and serial capture
  logic [15:0] div_cnt;
  logic        tick;
  logic        sck_rise;
  logic        sck_fall;
  logic [5:0]  bit_cnt;
  logic [5:0]  bit_cnt_inc;
  logic [5:0]  data_idx;
  logic [4:0]  pos;
  logic        primed;
  logic [5:0]  size;
  logic [4:0]  msb_idx;
  logic        capture;
  logic        push_req;
  logic [31:0] shreg;
  logic [31:0] shreg_nx;
  logic [31:0] sample;
  logic [31:0] push_word;

  // >= rather than == so a PR shrunk below the running count takes effect at once.
  assign tick        = en & (div_cnt >= pr);
  assign sck_rise    = tick & ~sck;
  assign sck_fall    = tick & sck;
  assign bit_cnt_inc = bit_cnt + 6'd1;
  // One-bit I2S delay: the rise in period k carries bit k-1 of the frame.
  assign data_idx    = bit_cnt - 6'd1;
  assign pos         = data_idx[4:0];
  assign size        = (cfg[9:4] == 6'd0 || cfg[9:4] > 6'd32) ? 6'd32 : cfg[9:4];
  assign msb_idx     = 5'(size - 6'd1);
  assign capture     = {1'b0, pos} < size;
  assign shreg_nx    = (pos == 5'd0) ? {31'd0, sdi} : {shreg[30:0], sdi};
  assign sample      = capture ? shreg_nx : shreg;
  assign push_req    = sck_rise & primed & (pos == 5'd31) & (data_idx[5] ? cfg[1] : cfg[0]);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    push_word = sample;
    if (cfg[3])
      push_word = sample << (6'd32 - size);
    else if (cfg[2] && sample[msb_idx])
      push_word = sample | (32'hFFFF_FFFF << size);
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      div_cnt <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
      bit_cnt <= '0;
      primed  <= 1'b0;
      shreg   <= '0;
    end else if (!en) begin
      div_cnt <= '0;
      sck     <= 1'b0;
      ws      <= 1'b0;
      bit_cnt <= '0;
      primed  <= 1'b0;
    end else begin
      div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
      if (tick) sck <= ~sck;
      if (sck_fall) begin
        bit_cnt <= bit_cnt_inc;
        ws      <= bit_cnt_inc[5];
      end
      if (sck_rise) begin
        if (pos == 5'd0) primed <= 1'b1;
        if (capture) shreg <= shreg_nx;
      end
    end
  end

  // RX FIFO
  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level;
  logic               empty;
  logic               full;
  logic               flush;
  logic               pop;
  logic               push;

  assign empty = (level == '0);
  assign full  = (level == (FIFO_AW+1)'(DEPTH));
  assign flush = wr_en & (addr == A_FLUSH) & PWDATA[0];
  assign pop   = rd_en & (addr == A_RXDATA) & ~empty;
  assign push  = push_req & ~full & ~flush;

  // NOTE: storage has no reset; level and pointers alone define which words are valid.
  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (FIFO_AW+1)'(1);
        2'b01:   level <= level - (FIFO_AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Sticky raw status; a condition present this cycle beats a same-cycle clear.
  logic [2:0] ris_set;
  logic [2:0] ris_clr;

  assign ris_set = {full, empty, int'(level) > int'(thr)};
  assign ris_clr = (wr_en && addr == A_IC) ? PWDATA[2:0] : 3'b000;

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      ris <= '0;
      IRQ <= 1'b0;
    end else begin
      ris <= (ris & ~ris_clr) | ris_set;
      IRQ <= |(ris & im);
    end
  end

  always_comb begin
    PRDATA = '0;
    case (addr)
      A_RXDATA: PRDATA = empty ? 32'd0 : mem[rd_ptr];
      A_PR:     PRDATA = {16'd0, pr};
      A_CTRL:   PRDATA = {31'd0, en};
      A_CFG:    PRDATA = {22'd0, cfg};
      A_LEVEL:  PRDATA = 32'(level);
      A_THR:    PRDATA = {28'd0, thr};
      A_IM:     PRDATA = {29'd0, im};
      A_MIS:    PRDATA = {29'd0, ris & im};
      A_RIS:    PRDATA = {29'd0, ris};
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_ef_i2s_apb.sv
// Directed bench for ef_i2s_apb: an I2S transmitter model drives sdi from the
// DUT's own sck, and words are checked through APB reads against hand values.
`timescale 1ns/1ps
module tb_ef_i2s_apb;
  localparam logic [15:0] A_RXDATA = 16'h0000;
  localparam logic [15:0] A_PR     = 16'h0004;
  localparam logic [15:0] A_CTRL   = 16'h0008;
  localparam logic [15:0] A_CFG    = 16'h000C;
  localparam logic [15:0] A_LEVEL  = 16'h0010;
  localparam logic [15:0] A_THR    = 16'h0014;
  localparam logic [15:0] A_FLUSH  = 16'h0018;
  localparam logic [15:0] A_IM     = 16'hFF00;
  localparam logic [15:0] A_MIS    = 16'hFF04;
  localparam logic [15:0] A_RIS    = 16'hFF08;
  localparam logic [15:0] A_IC     = 16'hFF0C;

  localparam logic [15:0] RST_ADDR [11] = '{A_RXDATA, A_PR, A_CTRL, A_CFG, A_LEVEL, A_THR,
                                           A_FLUSH, A_IM, A_MIS, A_RIS, A_IC};
  localparam logic [31:0] RST_EXP  [11] = '{32'h0, 32'h0, 32'h0, 32'h203, 32'h0, 32'h0,
                                           32'h0, 32'h0, 32'h0, 32'h2, 32'h0};

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic [31:0] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        sck;
  logic        ws;
  logic        sdi;
  logic        IRQ;

  int checks = 0;
  int failures = 0;

  ef_i2s_apb #(.FIFO_AW(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .sck(sck), .ws(ws), .sdi(sdi), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  // Transmitter model: period k (counted in sck falls since enable) carries
  // bit k-1 of the frame; slot n's sample is sent MSB first from bit 31.
  int          tb_falls = 0;
  int          tb_base = 0;
  logic        tb_seq = 1'b0;
  logic [31:0] stream_l = '0;
  logic [31:0] stream_r = '0;

  always @(negedge sck) tb_falls = tb_falls + 1;

  function automatic logic sdi_bit(input int k, input logic seq,
                                   input logic [31:0] wl, input logic [31:0] wr);
    int d;
    logic [31:0] w;
    if (k <= 0) return 1'b0;
    d = k - 1;
    if (seq) w = 32'hC0DE_0000 + 32'(d / 32);
    else     w = ((d / 32) % 2 == 0) ? wl : wr;
    return w[31 - (d % 32)];
  endfunction

  assign sdi = sdi_bit(tb_falls - tb_base, tb_seq, stream_l, stream_r);

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {16'h0, a}; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = {16'h0, a};
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic start_rx(input logic [15:0] pr, input logic [31:0] cfg);
    apb_write(A_CTRL, 32'h0);
    apb_write(A_FLUSH, 32'h1);
    apb_write(A_PR, {16'h0, pr});
    apb_write(A_CFG, cfg);
    tb_base = tb_falls;
    apb_write(A_CTRL, 32'h1);
  endtask

  task automatic wait_level(input int target, input string name);
    logic [31:0] v;
    int n;
    n = 0;
    do begin
      apb_read(A_LEVEL, v);
      n++;
    end while (v != 32'(target) && n < 600);
    checks++;
    if (v !== 32'(target)) begin
      failures++;
      $display("FAIL %s level got=%0d expected=%0d (timed out)", name, v, target);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    PRESETn = 1'b1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if ({sck, ws, IRQ, PREADY} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_pins got sck/ws/irq/pready=%b expected=0001", {sck, ws, IRQ, PREADY});
    end
    PRESETn = 1'b0;
    @(posedge PCLK);
    for (int i = 0; i < 11; i++) begin
      apb_read(RST_ADDR[i], v);
      checks++;
      if (v !== RST_EXP[i]) begin
        failures++;
        $display("FAIL reset_reg addr=%h got=%h expected=%h", RST_ADDR[i], v, RST_EXP[i]);
      end
    end
    apb_write(A_LEVEL, 32'h5);
    apb_write(A_RIS, 32'h0);
    apb_read(A_LEVEL, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL ro_level_write got=%h expected=%h", v, 32'h0);
    end
    apb_read(A_RIS, v);
    checks++;
    if (v !== 32'h2) begin
      failures++;
      $display("FAIL ro_ris_write got=%h expected=%h", v, 32'h2);
    end
  endtask

  task automatic test_stereo();
    logic [31:0] v;
    int r1, r2;
    logic prev;
    tb_seq = 1'b0;
    stream_l = 32'hA5A5_0000;
    stream_r = 32'h1234_0000;
    start_rx(16'd1, 32'h103);
    r1 = -1;
    r2 = -1;
    prev = sck;
    for (int c = 0; c < 200 && r2 < 0; c++) begin
      @(negedge PCLK);
      if (sck && !prev) begin
        if (r1 < 0) r1 = c;
        else r2 = c;
      end
      prev = sck;
    end
    checks++;
    if (r2 < 0 || (r2 - r1) != 4) begin
      failures++;
      $display("FAIL sck_period got=%0d expected=4", r2 - r1);
    end
    wait_level(2, "stereo_fill");
    apb_write(A_CTRL, 32'h0);
    apb_read(A_RXDATA, v);
    checks++;
    if (v !== 32'h0000_A5A5) begin
      failures++;
      $display("FAIL stereo_left got=%h expected=%h", v, 32'h0000_A5A5);
    end
    apb_read(A_RXDATA, v);
    checks++;
    if (v !== 32'h0000_1234) begin
      failures++;
      $display("FAIL stereo_right got=%h expected=%h", v, 32'h0000_1234);
    end
  endtask

  task automatic test_sign_justify();
    logic [31:0] v;
    tb_seq = 1'b0;
    stream_l = 32'h8001_0000;
    stream_r = 32'h0;
    start_rx(16'd0, 32'h105);
    wait_level(1, "sign_fill");
    apb_write(A_CTRL, 32'h0);
    apb_read(A_RXDATA, v);
    checks++;
    if (v !== 32'hFFFF_8001) begin
      failures++;
      $display("FAIL sign_extend got=%h expected=%h", v, 32'hFFFF_8001);
    end
    start_rx(16'd0, 32'h10D);
    wait_level(1, "justify_fill");
    apb_write(A_CTRL, 32'h0);
    apb_read(A_RXDATA, v);
    checks++;
    if (v !== 32'h8001_0000) begin
      failures++;
      $display("FAIL left_justify got=%h expected=%h", v, 32'h8001_0000);
    end
  endtask

  task automatic test_irq();
    logic [31:0] v;
    tb_seq = 1'b1;
    apb_write(A_THR, 32'd3);
    apb_write(A_IM, 32'h1);
    start_rx(16'd0, 32'h103);
    apb_write(A_IC, 32'h7);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("FAIL irq_idle got=%b expected=0", IRQ);
    end
    wait_level(4, "irq_fill");
    apb_write(A_CTRL, 32'h0);
    apb_read(A_RIS, v);
    checks++;
    if (v[0] !== 1'b1) begin
      failures++;
      $display("FAIL ris_threshold got=%h expected bit0=1", v);
    end
    @(negedge PCLK);
    checks++;
    if (IRQ !== 1'b1) begin
      failures++;
      $display("FAIL irq_threshold got=%b expected=1", IRQ);
    end
    for (int i = 0; i < 4; i++) apb_read(A_RXDATA, v);
    apb_write(A_IC, 32'h1);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if (IRQ !== 1'b0) begin
      failures++;
      $display("FAIL irq_cleared got=%b expected=0", IRQ);
    end
    apb_read(A_MIS, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL mis_cleared got=%h expected=%h", v, 32'h0);
    end
    apb_write(A_IM, 32'h0);
    apb_write(A_THR, 32'h0);
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    tb_seq = 1'b1;
    start_rx(16'd0, 32'h203);
    // 20 slots of 64 PCLK each at PR=0
    repeat (1320) @(posedge PCLK);
    apb_write(A_CTRL, 32'h0);
    apb_read(A_LEVEL, v);
    checks++;
    if (v !== 32'd16) begin
      failures++;
      $display("FAIL overflow_level got=%0d expected=16", v);
    end
    apb_read(A_RIS, v);
    checks++;
    if (v[2] !== 1'b1) begin
      failures++;
      $display("FAIL ris_full got=%h expected bit2=1", v);
    end
    for (int i = 0; i < 16; i++) begin
      apb_read(A_RXDATA, v);
      checks++;
      if (v !== 32'hC0DE_0000 + 32'(i)) begin
        failures++;
        $display("FAIL overflow_word%0d got=%h expected=%h", i, v, 32'hC0DE_0000 + 32'(i));
      end
    end
    apb_read(A_LEVEL, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL drained_level got=%0d expected=0", v);
    end
  endtask

  task automatic test_empty_flush();
    logic [31:0] v;
    apb_read(A_RXDATA, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL empty_read got=%h expected=%h", v, 32'h0);
    end
    apb_read(A_LEVEL, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL empty_read_level got=%0d expected=0", v);
    end
    tb_seq = 1'b1;
    start_rx(16'd0, 32'h203);
    wait_level(5, "flush_fill");
    apb_write(A_CTRL, 32'h0);
    apb_write(A_FLUSH, 32'h1);
    apb_read(A_LEVEL, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL flush_level got=%0d expected=0", v);
    end
  endtask

  task automatic test_midframe_reset();
    logic [31:0] v;
    tb_seq = 1'b1;
    start_rx(16'd0, 32'h101);
    repeat (150) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    checks++;
    if ({sck, ws} !== 2'b00) begin
      failures++;
      $display("FAIL midframe_pins got sck/ws=%b expected=00", {sck, ws});
    end
    PRESETn = 1'b0;
    apb_read(A_LEVEL, v);
    checks++;
    if (v !== 32'd0) begin
      failures++;
      $display("FAIL midframe_level got=%0d expected=0", v);
    end
    apb_read(A_CFG, v);
    checks++;
    if (v !== 32'h203) begin
      failures++;
      $display("FAIL midframe_cfg got=%h expected=%h", v, 32'h203);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stereo();
    test_sign_justify();
    test_irq();
    test_overflow();
    test_empty_flush();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
